// File: rtl/opb_slave_mux_ctrl.sv
// OPB slave front-end that decodes a window of register slaves and forwards one
// transfer at a time, terminating with an error ack if the slave stays silent.
//
// state | meaning
// IDLE  | waiting for a selected transfer that hits one of our windows
// FWD   | slave idx selected, wait counter running until ack, timeout or abort
// DONE  | one-cycle completion pulse on Sl_xferAck, then back to IDLE
module opb_slave_mux_ctrl #(
  parameter logic [31:0] C_BASEADDR   = 32'h0100B000,
  parameter logic [31:0] C_SLAVE_SPAN = 32'h00000100,
  parameter int          C_NUM_SLAVES = 4,
  parameter int          C_TIMEOUT    = 16
) (
  input  logic                        OPB_Clk,
  input  logic                        OPB_Rst,
  input  logic [0:31]                 OPB_ABus,
  input  logic                        OPB_select,
  input  logic                        OPB_RNW,
  input  logic                        OPB_seqAddr,
  output logic [0:31]                 Sl_DBus,
  output logic                        Sl_xferAck,
  output logic                        Sl_errAck,
  output logic                        Sl_retry,
  output logic                        Sl_toutSup,
  output logic [C_NUM_SLAVES-1:0]     slv_select,
  input  logic [32*C_NUM_SLAVES-1:0]  slv_DBus,
  input  logic [C_NUM_SLAVES-1:0]     slv_xferAck,
  input  logic [C_NUM_SLAVES-1:0]     slv_errAck,
  output logic [15:0]                 timeout_count
);

  localparam int                    LP_SHIFT  = $clog2(C_SLAVE_SPAN);
  localparam int                    LP_IW     = (C_NUM_SLAVES > 1) ? $clog2(C_NUM_SLAVES) : 1;
  localparam logic [32:0]           LP_WINDOW = 33'(C_NUM_SLAVES) * 33'(C_SLAVE_SPAN);
  localparam logic [15:0]           LP_TC     = 16'(C_TIMEOUT - 1);
  localparam logic [C_NUM_SLAVES-1:0] LP_ONE  = C_NUM_SLAVES'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [LP_IW-1:0]  r_idx;
  logic [15:0]       r_wait;

  logic [31:0]       w_addr;
  logic [31:0]       w_offset;
  logic [31:0]       w_idx_full;
  logic [LP_IW-1:0]  w_idx;
  logic              w_hit;
  logic              w_sel_ack;
  logic              w_sel_err;
  logic [31:0]       w_sel_data;
  logic              w_unused;

  assign w_addr     = OPB_ABus;
  assign w_offset   = w_addr - C_BASEADDR;
  assign w_idx_full = w_offset >> LP_SHIFT;
  assign w_idx      = w_idx_full[LP_IW-1:0];
  assign w_hit      = (w_addr >= C_BASEADDR) && ({1'b0, w_offset} < LP_WINDOW);

  // Only the slave we registered on entry may complete the transfer.
  assign w_sel_ack  = slv_xferAck[r_idx];
  assign w_sel_err  = slv_errAck[r_idx];
  assign w_sel_data = slv_DBus[{r_idx, 5'd0} +: 32];

  assign Sl_retry   = 1'b0;
  assign w_unused   = ^{OPB_seqAddr, w_idx_full};

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_wait        <= '0;
      Sl_DBus       <= '0;
      Sl_xferAck    <= 1'b0;
      Sl_errAck     <= 1'b0;
      Sl_toutSup    <= 1'b0;
      slv_select    <= '0;
      timeout_count <= '0;
    end else begin
      Sl_xferAck <= 1'b0;
      Sl_errAck  <= 1'b0;
      Sl_DBus    <= '0;
      case (r_state)
        S_IDLE: begin
          if (OPB_select && w_hit) begin
            r_state    <= S_FWD;
            r_idx      <= w_idx;
            r_wait     <= '0;
            slv_select <= LP_ONE << w_idx;
            Sl_toutSup <= 1'b1;
          end
        end
        S_FWD: begin
          if (!OPB_select) begin
            r_state    <= S_IDLE;
            r_wait     <= '0;
            slv_select <= '0;
            Sl_toutSup <= 1'b0;
          end else if (w_sel_ack) begin
            r_state    <= S_DONE;
            r_wait     <= '0;
            slv_select <= '0;
            Sl_toutSup <= 1'b0;
            Sl_xferAck <= 1'b1;
            Sl_errAck  <= w_sel_err;
            Sl_DBus    <= OPB_RNW ? w_sel_data : 32'h0;
          end else if (r_wait == LP_TC) begin
            r_state    <= S_DONE;
            r_wait     <= '0;
            slv_select <= '0;
            Sl_toutSup <= 1'b0;
            Sl_xferAck <= 1'b1;
            Sl_errAck  <= 1'b1;
            if (timeout_count != 16'hFFFF) timeout_count <= timeout_count + 16'd1;
          end else begin
            r_wait <= r_wait + 16'd1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_opb_slave_mux_ctrl.sv
// Randomized plus directed bench for opb_slave_mux_ctrl; expectations come from a
// transaction-level model of which event (ack, timeout, abort, reset) ends each transfer.
module tb_opb_slave_mux_ctrl;

  localparam logic [31:0] BASE = 32'h0100B000;
  localparam logic [31:0] SPAN = 32'h00000100;
  localparam int          NS   = 4;
  localparam int          T    = 16;

  logic              OPB_Clk = 1'b0;
  logic              OPB_Rst;
  logic [0:31]       OPB_ABus;
  logic              OPB_select;
  logic              OPB_RNW;
  logic              OPB_seqAddr;
  logic [0:31]       Sl_DBus;
  logic              Sl_xferAck;
  logic              Sl_errAck;
  logic              Sl_retry;
  logic              Sl_toutSup;
  logic [NS-1:0]     slv_select;
  logic [32*NS-1:0]  slv_DBus;
  logic [NS-1:0]     slv_xferAck;
  logic [NS-1:0]     slv_errAck;
  logic [15:0]       timeout_count;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] m_tcount = 16'h0;

  opb_slave_mux_ctrl #(
    .C_BASEADDR(BASE), .C_SLAVE_SPAN(SPAN), .C_NUM_SLAVES(NS), .C_TIMEOUT(T)
  ) dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .OPB_ABus(OPB_ABus),
    .OPB_select(OPB_select), .OPB_RNW(OPB_RNW), .OPB_seqAddr(OPB_seqAddr),
    .Sl_DBus(Sl_DBus), .Sl_xferAck(Sl_xferAck), .Sl_errAck(Sl_errAck),
    .Sl_retry(Sl_retry), .Sl_toutSup(Sl_toutSup), .slv_select(slv_select),
    .slv_DBus(slv_DBus), .slv_xferAck(slv_xferAck), .slv_errAck(slv_errAck),
    .timeout_count(timeout_count)
  );

  always #5 OPB_Clk = ~OPB_Clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {9'd0, Sl_xferAck, Sl_errAck, Sl_toutSup, Sl_retry, slv_select, Sl_DBus, timeout_count};
  endfunction

  // ack_k / abort_at / rst_at: FWD cycle number (1-based) of that event, 0 = none.
  task automatic run_xfer(input logic [31:0] addr, input logic rnw, input int ack_k,
                          input logic err, input logic [31:0] data,
                          input int abort_at, input int rst_at);
    logic        hit;
    int          idx;
    logic [NS-1:0] sel_mask;
    int          end_j, exp_fwd, exp_acks, exp_cyc;
    bit          is_to, is_ack, is_rst;
    logic        exp_err;
    logic [31:0] exp_d;
    int          fwd, acks, ack_cyc, bad;
    logic        got_err;
    logic [31:0] got_d;
    bit          rel_next, in_rst;

    hit      = (addr >= BASE) && ((addr - BASE) < NS * SPAN);
    idx      = hit ? int'((addr - BASE) / SPAN) : 0;
    sel_mask = hit ? (NS'(1) << idx) : '0;

    end_j = T; is_to = 1; is_ack = 0; is_rst = 0;
    if (ack_k >= 1 && ack_k <= T) begin end_j = ack_k; is_to = 0; is_ack = 1; end
    if (abort_at > 0 && abort_at < end_j) begin end_j = abort_at; is_to = 0; is_ack = 0; end
    if (rst_at > 0 && rst_at < end_j) begin end_j = rst_at; is_to = 0; is_ack = 0; is_rst = 1; end
    exp_fwd  = hit ? end_j : 0;
    exp_acks = (hit && (is_ack || is_to)) ? 1 : 0;
    exp_cyc  = (exp_acks != 0) ? end_j + 1 : 0;
    exp_err  = (exp_acks != 0) && (is_to || err);
    exp_d    = (hit && is_ack && rnw) ? data : 32'h0;

    OPB_ABus = addr; OPB_RNW = rnw; OPB_select = 1'b1;
    fwd = 0; acks = 0; ack_cyc = 0; bad = 0; got_err = 0; got_d = 0;
    rel_next = 0; in_rst = 0;
    for (int c = 1; c <= T + 6; c++) begin
      @(posedge OPB_Clk); #1;
      if (in_rst) begin
        chk("reset_mid_xfer_outs", all_outs(), 64'h0);
        OPB_Rst = 1'b0;
        in_rst = 0;
      end
      if (slv_select != '0) begin
        fwd++;
        if (slv_select !== sel_mask) bad++;
      end
      if (Sl_toutSup !== (slv_select != '0)) bad++;
      if (Sl_retry !== 1'b0) bad++;
      if (Sl_xferAck) begin
        acks++; ack_cyc = c; got_err = Sl_errAck; got_d = Sl_DBus;
      end else if (Sl_errAck || Sl_DBus != 32'h0) bad++;
      if (rel_next) OPB_select = 1'b0;
      rel_next = Sl_xferAck;

      slv_xferAck = NS'($urandom) & ~sel_mask;
      slv_errAck  = NS'($urandom);
      for (int s = 0; s < NS; s++) slv_DBus[32*s +: 32] = $urandom;
      if (hit) begin
        slv_DBus[32*idx +: 32] = data;
        slv_errAck[idx] = err;
        if (slv_select[idx] && fwd == ack_k) slv_xferAck[idx] = 1'b1;
        if (slv_select != '0 && fwd == abort_at) OPB_select = 1'b0;
        if (slv_select != '0 && fwd == rst_at) begin
          OPB_Rst = 1'b1; OPB_select = 1'b0; in_rst = 1;
        end
      end
    end
    OPB_select = 1'b0;
    slv_xferAck = '0;

    if (is_rst && hit) m_tcount = 16'h0;
    else if (is_to && hit && m_tcount != 16'hFFFF) m_tcount = m_tcount + 16'd1;

    chk("fwd_cycles", 64'(fwd), 64'(exp_fwd));
    chk("ack_count", 64'(acks), 64'(exp_acks));
    chk("ack_latency", 64'(ack_cyc), 64'(exp_cyc));
    chk("err_ack", 64'(got_err), 64'(exp_err));
    chk("read_data", 64'(got_d), 64'(exp_d));
    chk("protocol", 64'(bad), 64'h0);
    chk("timeout_count", 64'(timeout_count), 64'(m_tcount));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          r, ack_k, abort_at, rst_at;
    logic [31:0] addr;

    OPB_Rst = 1'b1; OPB_select = 1'b0; OPB_ABus = '0; OPB_RNW = 1'b0; OPB_seqAddr = 1'b0;
    slv_DBus = '0; slv_xferAck = '0; slv_errAck = '0;
    repeat (3) @(posedge OPB_Clk);
    #1;
    chk("reset_outs", all_outs(), 64'h0);
    OPB_Rst = 1'b0;
    @(posedge OPB_Clk); #1;
    chk("idle_outs", all_outs(), 64'h0);

    run_xfer(32'h0100B204, 1'b1, 3,  1'b0, 32'hDEADBEEF, 0, 0);
    run_xfer(32'h0100B000, 1'b0, 1,  1'b0, 32'h12345678, 0, 0);
    run_xfer(32'h0100B3FC, 1'b1, 0,  1'b0, 32'hCAFEF00D, 0, 0);
    run_xfer(32'h0100C000, 1'b1, 1,  1'b0, 32'h11111111, 0, 0);
    run_xfer(32'h0100B100, 1'b1, 16, 1'b0, 32'hA5A5A5A5, 0, 0);
    run_xfer(32'h0100B104, 1'b1, 0,  1'b0, 32'h5A5A5A5A, 6, 0);
    run_xfer(32'h0100B3FC, 1'b1, 0,  1'b0, 32'h0, 0, 0);
    run_xfer(32'h0100B208, 1'b1, 0,  1'b0, 32'h22222222, 0, 4);
    run_xfer(32'h0100B20C, 1'b1, 2,  1'b0, 32'h13572468, 0, 0);
    run_xfer(32'h0100B008, 1'b1, 1,  1'b1, 32'h0BADF00D, 0, 0);
    run_xfer(32'h0100AFFC, 1'b1, 1,  1'b0, 32'h33333333, 0, 0);

    for (int n = 0; n < 40; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8) addr = BASE + ($urandom_range(0, NS * SPAN - 1) & ~32'h3);
      else if (r == 8) addr = BASE - 32'(4 * $urandom_range(1, 64));
      else addr = BASE + NS * SPAN + ($urandom_range(0, 1023) & ~32'h3);
      ack_k = $urandom_range(0, T + 3);
      abort_at = ($urandom_range(0, 5) == 0) ? $urandom_range(1, T - 1) : 0;
      if (abort_at == ack_k) abort_at = 0;
      rst_at = ($urandom_range(0, 9) == 0) ? $urandom_range(1, T - 1) : 0;
      if (rst_at == ack_k || rst_at == abort_at) rst_at = 0;
      run_xfer(addr, 1'($urandom), ack_k, 1'($urandom), $urandom, abort_at, rst_at);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
